// File: rtl/pacram_banked_controller_if.sv
// pacram_banked_controller_if: SDRAM transfer-size package plus the MSX slot bus and SDRAM port interfaces
package RAM;
  typedef enum logic [1:0] {DIN_SIZE_8, DIN_SIZE_16, DIN_SIZE_32} din_size_t;
endpackage

interface BUS_IF;
  logic [15:0] ADDR;
  logic [7:0] DIN;
  logic [7:0] DOUT;
  logic SLTSL_n, MERQ_n, RD_n, WR_n, RESET_n, RFSH_n;
  logic BUSDIR_n, INT_n, WAIT_n;
  modport CARTRIDGE(
    input ADDR, DIN, SLTSL_n, MERQ_n, RD_n, WR_n, RESET_n, RFSH_n,
    output DOUT, BUSDIR_n, INT_n, WAIT_n
  );
  modport MSX(
    output ADDR, DIN, SLTSL_n, MERQ_n, RD_n, WR_n, RESET_n, RFSH_n,
    input DOUT, BUSDIR_n, INT_n, WAIT_n
  );
endinterface

interface RAM_IF;
  logic [26:0] ADDR;
  logic [7:0] DIN;
  logic [7:0] DOUT;
  logic WE_n, OE_n, RFSH_n;
  RAM::din_size_t DIN_SIZE;
  modport HOST(output ADDR, DIN, WE_n, OE_n, RFSH_n, DIN_SIZE, input DOUT);
  modport DEVICE(input ADDR, DIN, WE_n, OE_n, RFSH_n, DIN_SIZE, output DOUT);
endinterface

// File: rtl/pacram_banked_controller.sv
// pacram_banked_controller: PAC cartridge mapping BIOS and banked, key-unlocked SRAM onto SDRAM, with zero-fill engine
module pacram_banked_controller #(
  parameter int unsigned RAM_ADDR_BIOS = 0,
  parameter int unsigned RAM_ADDR_PAC = 0,
  parameter int unsigned PAGE_BITS = 2
) (
  input logic CLK,
  input logic RESET_n,
  BUS_IF.CARTRIDGE Bus,
  RAM_IF.HOST Ram,
  input logic PROTECT,
  input logic CLR_REQ,
  output logic CLR_BUSY,
  output logic DIRTY
);
  localparam int CW = PAGE_BITS + 13;
  localparam int BW = PAGE_BITS > 0 ? PAGE_BITS : 1;
  localparam logic [26:0] BIOS_BASE = RAM_ADDR_BIOS[26:0];
  localparam logic [26:0] PAC_BASE = RAM_ADDR_PAC[26:0];
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [BW-1:0] bank;
  logic [7:0] key0, key1, key0_nx, key1_nx, dout, dout_nx, din_q, din_nx;
  logic [26:0] addr_q, addr_nx, sram_addr, bios_addr, fill_addr;
  logic wr_prev, wr_prev_nx, we_n, we_nx, oe_n, oe_nx, busdir_n, busdir_nx, rfsh_n;
  logic rd, wr, page1, det_wr, unlock, sram, key_rd, bank_rd, msx, sram_wr, ram_rd, fill_wr, bus_rst;
  assign bus_rst = !Bus.RESET_n;
  assign rd = !Bus.SLTSL_n && !Bus.MERQ_n && !Bus.RD_n;
  assign wr = !Bus.SLTSL_n && !Bus.MERQ_n && !Bus.WR_n;
  assign page1 = Bus.ADDR[15:14] == 2'b01;
  assign det_wr = wr && !wr_prev;
  assign unlock = key0 == 8'h4D && key1 == 8'h69;
  assign sram = page1 && unlock && Bus.ADDR < 16'h5FFE;
  assign key_rd = unlock && (Bus.ADDR == 16'h5FFE || Bus.ADDR == 16'h5FFF);
  assign bank_rd = unlock && Bus.ADDR == 16'h7FF7;
  assign msx = page1 && (rd || wr);
  assign sram_wr = wr && sram && !PROTECT;
  assign sram_addr = PAC_BASE + {14'(bank), Bus.ADDR[12:0]};
  assign bios_addr = BIOS_BASE + {13'd0, Bus.ADDR[13:0]};
  assign fill_addr = PAC_BASE + 27'(cnt);
  if (PAGE_BITS > 0) begin : g_bank
    always_ff @(posedge CLK or negedge RESET_n)
      if (!RESET_n) bank <= '0;
      else bank <= bus_rst ? '0 : det_wr && Bus.ADDR == 16'h7FF7 ? Bus.DIN[BW-1:0] : bank;
  end else begin : g_no_bank
    assign bank = '0;
  end
  always_ff @(posedge CLK or negedge RESET_n)
    if (!RESET_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = bus_rst ? IDLE
             : state == IDLE ? (CLR_REQ ? FILL : IDLE)
             : state == FILL ? (!msx && &cnt ? DONE : FILL)
             : IDLE;
  // MSX accesses in page 1 always win the SDRAM port; the fill only advances on free cycles
  always_comb begin
    fill_wr = state == FILL && !msx;
    ram_rd = rd && page1 && !key_rd && !bank_rd;
    cnt_nx = bus_rst || state == IDLE ? '0 : fill_wr ? cnt + 1'b1 : cnt;
    key0_nx = bus_rst ? '0 : det_wr && Bus.ADDR == 16'h5FFE ? Bus.DIN : key0;
    key1_nx = bus_rst ? '0 : det_wr && Bus.ADDR == 16'h5FFF ? Bus.DIN : key1;
    wr_prev_nx = !bus_rst && wr;
    we_nx = bus_rst || !(sram_wr || fill_wr);
    oe_nx = bus_rst || !ram_rd;
    addr_nx = bus_rst ? '0 : ram_rd || sram_wr ? (sram ? sram_addr : bios_addr) : fill_wr ? fill_addr : '0;
    din_nx = bus_rst || !sram_wr ? '0 : Bus.DIN;
    busdir_nx = bus_rst || !(rd && page1);
    dout_nx = bus_rst || !(rd && page1) ? '0
            : key_rd ? (Bus.ADDR[0] ? key1 : key0)
            : bank_rd ? 8'(bank)
            : Ram.DOUT;
  end
  always_ff @(posedge CLK or negedge RESET_n)
    if (!RESET_n) begin
      cnt <= '0;
      key0 <= '0;
      key1 <= '0;
      wr_prev <= 1'b0;
      we_n <= 1'b1;
      oe_n <= 1'b1;
      addr_q <= '0;
      din_q <= '0;
      busdir_n <= 1'b1;
      dout <= '0;
      rfsh_n <= 1'b1;
    end else begin
      cnt <= cnt_nx;
      key0 <= key0_nx;
      key1 <= key1_nx;
      wr_prev <= wr_prev_nx;
      we_n <= we_nx;
      oe_n <= oe_nx;
      addr_q <= addr_nx;
      din_q <= din_nx;
      busdir_n <= busdir_nx;
      dout <= dout_nx;
      rfsh_n <= Bus.RFSH_n;
    end
  // SRAM contents survive a slot reset, so only the power-on reset forgets DIRTY
  always_ff @(posedge CLK or negedge RESET_n)
    if (!RESET_n) DIRTY <= 1'b0;
    else DIRTY <= bus_rst ? DIRTY : sram_wr ? 1'b1 : state == DONE ? 1'b0 : DIRTY;
  assign CLR_BUSY = state != IDLE;
  assign Ram.ADDR = addr_q;
  assign Ram.DIN = din_q;
  assign Ram.WE_n = we_n;
  assign Ram.OE_n = oe_n;
  assign Ram.RFSH_n = rfsh_n;
  assign Ram.DIN_SIZE = RAM::DIN_SIZE_8;
  assign Bus.DOUT = dout;
  assign Bus.BUSDIR_n = busdir_n;
  assign Bus.INT_n = 1'b1;
  assign Bus.WAIT_n = 1'b1;
endmodule

// File: doc/pacram_banked_controller.md
PACRAM_BANKED_CONTROLLER -- requirements
Module: pacram_banked_controller

Interface
REQ-001 SHALL have parameter RAM_ADDR_BIOS, default 0: 16 KB-aligned SDRAM base of the PAC BIOS image.
REQ-002 SHALL have parameter RAM_ADDR_PAC, default 0: 8 KB-aligned SDRAM base of page 0 of the SRAM area.
REQ-003 SHALL have parameter PAGE_BITS, default 2, legal range 0-4: the SRAM area has 2^PAGE_BITS pages of 8 KB each.
REQ-004 SHALL have port CLK, input, 1 bit: system clock; all logic is rising-edge.
REQ-005 SHALL have port RESET_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port Bus, BUS_IF.CARTRIDGE modport: the MSX slot bus.
REQ-007 SHALL have port Ram, RAM_IF.HOST modport: the SDRAM port.
REQ-008 SHALL have port PROTECT, input, 1 bit: when high, blocks MSX writes to the SRAM area.
REQ-009 SHALL have port CLR_REQ, input, 1 bit: single-cycle request to start a zero-fill of the whole SRAM area.
REQ-010 SHALL have port CLR_BUSY, output, 1 bit: high while a zero-fill is in progress.
REQ-011 SHALL have port DIRTY, output, 1 bit: high when the SRAM area has been written since the last completed fill.

Function
REQ-012 SHALL define the strobes: rd = !SLTSL_n & !MERQ_n & !RD_n; wr = !SLTSL_n & !MERQ_n & !WR_n; page1 = ADDR[15:14]==01.
REQ-013 SHALL detect a write by registering wr each CLK; det_wr = wr & !wr_prev, one pulse per MSX write.
REQ-014 SHALL, on det_wr at 5FFE/5FFF, store DIN into KEY0/KEY1; UNLOCK = (KEY0==4D && KEY1==69).
REQ-015 SHALL, on det_wr at 7FF7, store DIN[PAGE_BITS-1:0] into BANK, regardless of UNLOCK; with PAGE_BITS=0, BANK is absent.
REQ-016 SHALL decode, with UNLOCK=1 and ADDR in 4000-5FFD, ADDR as SRAM at RAM_ADDR_PAC + BANK*2000h + ADDR[12:0].
REQ-017 SHALL decode every other page1 address as BIOS at RAM_ADDR_BIOS + ADDR[13:0], read-only.
REQ-018 SHALL, on rd at 5FFE/5FFF with UNLOCK=1, return KEY0/KEY1 from the registers, not from RAM.
REQ-019 SHALL, on rd at 7FF7 with UNLOCK=1, return {zeros, BANK}.
REQ-020 SHALL perform an MSX SRAM write when wr & page1 & SRAM-decoded & !PROTECT, and set DIRTY.
REQ-021 SHALL ignore writes to the BIOS area and writes while PROTECT=1; the key and bank registers are still written.
REQ-022 SHALL register all Ram outputs and Bus.DOUT/Bus.BUSDIR_n: exactly 1 CLK latency from the strobe to the output.
REQ-023 SHALL drive Bus.BUSDIR_n=0 only for rd & page1, and Bus.DOUT=0 when not reading.
REQ-024 SHALL drive Ram.ADDR=0, Ram.DIN=0, Ram.WE_n=1, Ram.OE_n=1 when no access is active; Ram.DIN_SIZE SHALL be RAM::DIN_SIZE_8; Ram.RFSH_n SHALL be Bus.RFSH_n registered.
REQ-025 SHALL drive Bus.INT_n=1 and Bus.WAIT_n=1 constantly.
REQ-026 SHALL implement a fill FSM with states IDLE, FILL, DONE.
REQ-027 SHALL move IDLE->FILL on CLR_REQ=1 and clear CNT (PAGE_BITS+13 bits) to 0; CLR_REQ SHALL be ignored outside IDLE.
REQ-028 SHALL, in FILL, on each CLK with no MSX rd or wr in page1, write 00 to RAM_ADDR_PAC+CNT and increment CNT.
REQ-029 SHALL, in FILL, give an MSX access priority and pause CNT for that cycle; PROTECT SHALL NOT block the fill.
REQ-030 SHALL move FILL->DONE after the write at CNT = all-ones (wrap point).
REQ-031 SHALL, in DONE, clear DIRTY for one cycle and then return to IDLE; an MSX SRAM write in the DONE cycle SHALL leave DIRTY=1.
REQ-032 SHALL hold CLR_BUSY=1 in FILL and DONE, and 0 in IDLE.

Reset
REQ-033 SHALL, on RESET_n=0 (async) or Bus.RESET_n=0 (sync), clear KEY0, KEY1 and BANK to 0, put the FSM in IDLE, clear CNT to 0, clear wr_prev to 0, and clear CLR_BUSY to 0.
REQ-034 SHALL, on the same resets, drive Ram.WE_n=1, Ram.OE_n=1, Ram.ADDR=0, Ram.DIN=0, Bus.BUSDIR_n=1 and Bus.DOUT=0.
REQ-035 SHALL clear DIRTY only on RESET_n; Bus.RESET_n SHALL leave DIRTY unchanged, because the SRAM contents survive it.
REQ-036 SHALL abort a fill in progress on Bus.RESET_n and return to IDLE with DIRTY unchanged.

Verification
REQ-037 SHALL cover: write 4D->5FFE, 69->5FFF, 02->7FF7, then write A5 to 4123 -> Ram write at RAM_ADDR_PAC+4123h, DIRTY=1.
REQ-038 SHALL cover: same write with PROTECT=1 -> no Ram.WE_n pulse, DIRTY unchanged; read of 5FFE returns 4D.
REQ-039 SHALL cover: locked (KEY0=00), read of 4123 -> Ram.OE_n=0 at RAM_ADDR_BIOS+0123h, BUSDIR_n=0 one CLK after the strobe.
REQ-040 SHALL cover: PAGE_BITS=1, CLR_REQ pulse -> 16384 zero writes from RAM_ADDR_PAC, CLR_BUSY high throughout, DIRTY=0 at DONE.
REQ-041 SHALL cover: an MSX read during FILL -> that cycle services the read, CNT holds, total fill writes still 2^(PAGE_BITS+13).
REQ-042 SHALL cover: Bus.RESET_n pulse mid-fill -> FSM IDLE, KEY0/KEY1/BANK=0, DIRTY kept; RESET_n -> DIRTY=0.
